disp_bcd_scan: RTL and testbench
================================

// Module: disp_bcd_scan
// PURPOSE
//   Consumer stage after the clock-domain-crossing FIFO wrapper, on the clk domain.
//   Captures each 16-bit word popped from the FIFO (data_2/data_2_valid).
//   Converts the word to 5 BCD digits with a sequential double-dabble engine.
//   Time-multiplexes 8 seven-segment digits: value, active prog speed, active module letter.
// PARAMETERS
//   DATA_W    16       width of the incoming binary word (unsigned)
//   SCAN_DIV  100000   clk cycles each digit stays lit; >=2; benches use 4
// PORTS
//   clk         in   1       system clock
//   rst         in   1       reset, asynchronous, active-high
//   data_in     in   DATA_W  word from FIFO read side
//   data_valid  in   1       one-cycle strobe: data_in valid this cycle
//   modulo      in   2       2'b10 fibonacci, 2'b01 timer, else none
//   prog        in   3       registered clock-program index, shown as digit 0-7
//   busy        out  1       conversion in progress
//   an          out  8       digit enables, active-low, one-hot-zero
//   dec_ddp     out  8       {a,b,c,d,e,f,g,dp}, active-low
// BEHAVIOUR
//   Reset values: an=8'hFF, dec_ddp=8'hFF, busy=0, shown value=0, pending=0, scan idx=0, scan cnt=0.
//   Conversion FSM:
//     CONV_IDLE: data_valid -> latch data_in, go CONV_SHIFT.
//     CONV_SHIFT: 16 iterations of add-3-if->=5 on each nibble, then shift left 1.
//       After 16 iterations, go CONV_LOAD.
//     CONV_LOAD: copy 5 BCD digits to display register, go CONV_IDLE.
//       If a pending word exists, go CONV_SHIFT with it instead.
//   Latency: display register updates exactly 18 clk after the data_valid cycle (1 latch + 16 shift + 1 load).
//   busy=1 from the cycle after capture through the CONV_LOAD cycle.
//   data_valid while busy: word stored in a 1-entry pending register.
//     A newer word overwrites an older pending word; only the newest survives.
//     No backpressure to the FIFO.
//   data_valid in the same cycle as CONV_LOAD: the word becomes the next conversion directly.
//   Max input 65535 -> BCD 6_5_5_3_5. All 5 digits are needed; no overflow is possible for DATA_W=16.
//   Scan:
//     Counter counts 0..SCAN_DIV-1; at terminal count, idx <= idx+1 (mod 8, wraps 7->0).
//     an <= ~(1<<idx) and dec_ddp <= seg(idx) are registered, 1 clk after the idx change.
//     First digit lights SCAN_DIV cycles after reset release.
//   Digit map:
//     idx 0-4: BCD units..ten-thousands. Leading zeros blank (8'hFF); idx0 always shown, so 0 shows "0".
//     idx 5: blank.
//     idx 6: prog as hex glyph 0-7.
//     idx 7: 'F' if modulo=10, 't' if modulo=01, blank otherwise (11 treated as none).
//   modulo/prog are sampled live at each digit refresh; they are not latched with data.
//   dp is always off: dec_ddp[0]=1.
//   rst mid-conversion: async clear of everything; the in-flight and pending words are discarded.
// STRUCTURE
//   Shared package (disp_pkg):
//     SEG_0..SEG_9, SEG_F, SEG_T, SEG_BLANK (8-bit active-low codes);
//     MOD_FIB=2'b10, MOD_TMR=2'b01, MOD_NONE=2'b00;
//     conversion state encodings.
//   Sub-module bin2bcd_seq: clk, rst, start, bin[DATA_W-1:0] -> bcd[19:0], done, busy (double-dabble FSM).
//   Parent contains: pending register, scan counter/index, glyph mux, output registers.
// TESTING (SCAN_DIV=4)
//   1. Reset release, no data -> an=FF,dec=FF for 4 clk; then an=FE, dec=SEG_0; idx1..5 blank.
//   2. data_in=12345 strobe -> busy high 17 clk; display digits 5,4,3,2,1 on an FE..EF; 18 clk after strobe register=12345.
//   3. data_in=65535 -> digits 6,5,5,3,5. Then data_in=7 -> idx1-4 blank, idx0=SEG_7.
//   4. Strobes 100, 200, 300 on consecutive cycles -> 100 converted, 300 converted next; 200 never shown; final display 300.
//   5. modulo=10,prog=5 -> an=7F shows SEG_F, an=BF shows SEG_5; modulo=01 -> SEG_T; modulo=11 -> blank.
//   6. Assert rst 5 clk into conversion of 999 -> all outputs at reset values immediately; after release display "0", busy=0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants for the BCD display slice: active-low segment glyphs,
// modulo selector codes and the conversion state encoding.
package disp_pkg;

    // Glyph layout is {a,b,c,d,e,f,g,dp}; a 0 lights the segment and dp stays dark.
    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_T     = 8'hE1;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [1:0] MOD_FIB  = 2'b10;
    localparam logic [1:0] MOD_TMR  = 2'b01;
    localparam logic [1:0] MOD_NONE = 2'b00;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_LOAD  = 2'd2
    } conv_state_t;

    function automatic logic [7:0] seg_of(input logic [3:0] d);
        logic [7:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// a single-cycle LOAD state that presents the result and can chain a new start.
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic [19:0]       bcd,
    output logic              done,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    conv_state_t       state, state_nx;
    logic [19:0]       bcd_q;
    logic [19:0]       bcd_adj;
    logic [DATA_W-1:0] bin_q;
    logic [CNT_W-1:0]  iter;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            CONV_IDLE:  if (start) state_nx = CONV_SHIFT;
            CONV_SHIFT: if (iter == CNT_W'(DATA_W - 1)) state_nx = CONV_LOAD;
            CONV_LOAD:  state_nx = start ? CONV_SHIFT : CONV_IDLE;
            default:    state_nx = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CONV_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // bcd_q is still valid during LOAD, so a chained start may clear it on that edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcd_q <= '0;
            bin_q <= '0;
            iter  <= '0;
        end else begin
            case (state)
                CONV_IDLE, CONV_LOAD: begin
                    if (start) begin
                        bcd_q <= '0;
                        bin_q <= bin;
                        iter  <= '0;
                    end
                end
                CONV_SHIFT: begin
                    bcd_q <= {bcd_adj[18:0], bin_q[DATA_W-1]};
                    bin_q <= {bin_q[DATA_W-2:0], 1'b0};
                    iter  <= iter + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bcd  = bcd_q;
    assign done = (state == CONV_LOAD);
    assign busy = (state != CONV_IDLE);

endmodule

// File: rtl/disp_bcd_scan.sv
// FIFO-side consumer: converts each popped word to BCD and scans value,
// program index and module letter across eight multiplexed 7-segment digits.
module disp_bcd_scan
    import disp_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SCAN_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    input  logic [1:0]        modulo,
    input  logic [2:0]        prog,
    output logic              busy,
    output logic [7:0]        an,
    output logic [7:0]        dec_ddp
);

    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic              conv_start;
    logic [DATA_W-1:0] conv_bin;
    logic [19:0]       conv_bcd;
    logic              conv_done;
    logic              conv_busy;
    logic [DATA_W-1:0] pend_word;
    logic              pend_valid;
    logic [19:0]       shown_bcd;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        scan_idx;
    logic              scan_tick;
    logic [4:0]        lead_nz;
    logic [7:0]        glyph;

    // A word arriving in the LOAD cycle is newer than anything pending, so it wins.
    always_comb begin
        conv_start = 1'b0;
        conv_bin   = data_in;
        if (!conv_busy) begin
            conv_start = data_valid;
        end else if (conv_done) begin
            conv_start = data_valid || pend_valid;
            conv_bin   = data_valid ? data_in : pend_word;
        end
    end

    bin2bcd_seq #(
        .DATA_W(DATA_W)
    ) u_conv (
        .clk  (clk),
        .rst  (rst),
        .start(conv_start),
        .bin  (conv_bin),
        .bcd  (conv_bcd),
        .done (conv_done),
        .busy (conv_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_word  <= '0;
            pend_valid <= 1'b0;
            shown_bcd  <= '0;
        end else begin
            if (conv_done) begin
                pend_valid <= 1'b0;
                shown_bcd  <= conv_bcd;
            end else if (conv_busy && data_valid) begin
                pend_word  <= data_in;
                pend_valid <= 1'b1;
            end
        end
    end

    assign busy      = conv_busy;
    assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_tick) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // lead_nz[k] is set when digit k or any more significant digit is non-zero.
    always_comb begin
        lead_nz    = '0;
        lead_nz[4] = |shown_bcd[19:16];
        for (int k = 3; k >= 0; k--) begin
            lead_nz[k] = lead_nz[k+1] | (|shown_bcd[k*4 +: 4]);
        end
    end

    always_comb begin
        glyph = SEG_BLANK;
        case (scan_idx)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
                if (scan_idx == 3'd0 || lead_nz[scan_idx]) begin
                    glyph = seg_of(shown_bcd[{scan_idx, 2'b00} +: 4]);
                end
            end
            3'd6: glyph = seg_of({1'b0, prog});
            3'd7: begin
                case (modulo)
                    MOD_FIB: glyph = SEG_F;
                    MOD_TMR: glyph = SEG_T;
                    default: glyph = SEG_BLANK;
                endcase
            end
            default: glyph = SEG_BLANK;
        endcase
    end

    // Digit outputs refresh once per scan period, showing the index that period belonged to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an      <= 8'hFF;
            dec_ddp <= 8'hFF;
        end else if (scan_tick) begin
            an      <= ~(8'h01 << scan_idx);
            dec_ddp <= glyph;
        end
    end

endmodule

// File: tb/tb_disp_bcd_scan.sv
// Self-checking bench for disp_bcd_scan: directed scenarios plus random words,
// checked against a decimal/glyph reference model computed with plain arithmetic.
module tb_disp_bcd_scan;

    localparam int DATA_W   = 16;
    localparam int SCAN_DIV = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic [1:0]        modulo;
    logic [2:0]        prog;
    logic              busy;
    logic [7:0]        an;
    logic [7:0]        dec_ddp;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_bcd_scan #(
        .DATA_W  (DATA_W),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .modulo    (modulo),
        .prog      (prog),
        .busy      (busy),
        .an        (an),
        .dec_ddp   (dec_ddp)
    );

    function automatic logic [7:0] refGlyph(input int d);
        logic [7:0] tbl [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};
        return tbl[d];
    endfunction

    // Expected segment pattern for scan position idx when showing value.
    function automatic logic [7:0] expDigit(input int value, input int idx,
                                            input logic [1:0] m, input logic [2:0] p);
        int pw = 1;
        if (idx <= 4) begin
            for (int k = 0; k < idx; k++) pw = pw * 10;
            if (idx == 0 || value >= pw) return refGlyph((value / pw) % 10);
            return 8'hFF;
        end
        if (idx == 6) return refGlyph(int'(p));
        if (idx == 7) begin
            if (m == 2'b10) return 8'h71;
            if (m == 2'b01) return 8'hE1;
        end
        return 8'hFF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] word);
        @(negedge clk);
        data_in    = word;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_wait", {31'd0, busy}, 32'd0);
    endtask

    // Walks all eight scan positions, assuming the caller is inside digit 0's period.
    task automatic checkScan(input int value, input logic [1:0] m, input logic [2:0] p);
        logic [7:0] one_hot;
        for (int d = 0; d < 8; d++) begin
            one_hot = 8'h01 << d;
            checkOutput($sformatf("an_d%0d", d), {24'd0, an}, {24'd0, ~one_hot});
            checkOutput($sformatf("seg_d%0d_v%0d", d, value), {24'd0, dec_ddp},
                        {24'd0, expDigit(value, d, m, p)});
            repeat (SCAN_DIV) @(negedge clk);
        end
    endtask

    task automatic checkFrame(input int value, input logic [1:0] m, input logic [2:0] p);
        int n;
        modulo = m;
        prog   = p;
        n = 0;
        while (an == 8'hFE && n < 100) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (an != 8'hFE && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_sync", {24'd0, an}, 32'h0000_00FE);
        checkScan(value, m, p);
    endtask

    initial begin
        int n;
        int w;
        rst        = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        modulo     = 2'b00;
        prog       = 3'd0;

        // Reset values, then first digit lights SCAN_DIV cycles after release.
        repeat (3) @(negedge clk);
        checkOutput("rst_an", {24'd0, an}, 32'h0000_00FF);
        checkOutput("rst_dec", {24'd0, dec_ddp}, 32'h0000_00FF);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < SCAN_DIV; i++) begin
            checkOutput("pre_scan_an", {24'd0, an}, 32'h0000_00FF);
            checkOutput("pre_scan_dec", {24'd0, dec_ddp}, 32'h0000_00FF);
            @(negedge clk);
        end
        checkScan(0, 2'b00, 3'd0);

        // Busy spans capture+1 through the load cycle: 17 clocks.
        applyStimulus(16'd12345);
        for (int i = 0; i < 17; i++) begin
            checkOutput($sformatf("busy_hi_%0d", i), {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        checkOutput("busy_lo_after", {31'd0, busy}, 32'd0);
        checkFrame(12345, 2'b00, 3'd0);

        applyStimulus(16'd65535);
        waitIdle();
        checkFrame(65535, 2'b00, 3'd3);
        applyStimulus(16'd7);
        waitIdle();
        checkFrame(7, 2'b00, 3'd3);

        // Back-to-back strobes: 100 converts, 300 overwrites 200 and chains directly.
        @(negedge clk);
        data_in    = 16'd100;
        data_valid = 1'b1;
        @(negedge clk);
        data_in    = 16'd200;
        @(negedge clk);
        data_in    = 16'd300;
        @(negedge clk);
        data_valid = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        checkOutput("chain_busy_len", n, 32'd32);
        checkFrame(300, 2'b00, 3'd0);

        checkFrame(300, 2'b10, 3'd5);
        checkFrame(300, 2'b01, 3'd2);
        checkFrame(300, 2'b11, 3'd7);

        for (int r = 0; r < 6; r++) begin
            w = int'($urandom_range(0, 65535));
            applyStimulus(DATA_W'(w));
            waitIdle();
            checkFrame(w, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
        end

        // Reset mid-conversion discards both the in-flight and the pending word.
        applyStimulus(16'd999);
        repeat (4) @(negedge clk);
        applyStimulus(16'd4321);
        rst = 1'b1;
        #1;
        checkOutput("midrst_an", {24'd0, an}, 32'h0000_00FF);
        checkOutput("midrst_dec", {24'd0, dec_ddp}, 32'h0000_00FF);
        checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) n++;
            @(negedge clk);
        end
        checkOutput("post_rst_busy_cycles", n, 32'd0);
        checkFrame(0, 2'b00, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
